seg_scan_reader: RTL and testbench
==================================

Name: seg_scan_reader

Overview:
- Receive-side counterpart of the hex-to-seven-segment display path.
- Monitors a multiplexed, active-low seven-segment bus (segment pattern plus scanned digit selects).
- Debounces each digit dwell, reverse-decodes the pattern to a 4-bit hex value, and assembles one value per digit into a frame.
- Delivers frames over a valid/ready handshake. Used for display self-check and board-level loopback.

Parameters:
- DIGITS, 4: number of scanned digits; range 1..8.
- STABLE_CYCLES, 4: consecutive identical samples needed before a digit is captured; range 1..255.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous reset, active-low.
- seg_in  in  8  segment bus, active-low; bit6..0 = g,f,e,d,c,b,a; bit7 (dp) is ignored.
- dig_sel  in  DIGITS  digit enables, active-low; exactly one bit is low during a valid dwell.
- frame_data  out  4*DIGITS  decoded nibbles; digit i is at [4i+3:4i].
- frame_err  out  DIGITS  bit i = digit i pattern was not a legal glyph.
- frame_blank  out  DIGITS  bit i = digit i pattern was blank (7'h7F).
- frame_valid  out  1  frame available; held until accepted.
- frame_ready  in  1  consumer accepts the frame when frame_valid & frame_ready.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

Behaviour:
- Decode table (seg_in[6:0] -> value):
  - 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7
  - 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F
  - 7F -> value 0, blank=1, err=0.
  - Any other pattern -> value 0, err=1, blank=0.
- Stability counter:
  - Width is clog2(STABLE_CYCLES+1). The previous sample is registered.
  - The counter increments while {seg_in[6:0], dig_sel} equals the previous sample and dig_sel is one-hot-low.
  - It reloads to 1 on any change and to 0 when dig_sel is not one-hot-low (all high, or two or more low).
  - It saturates at STABLE_CYCLES.
- Capture:
  - On the edge where the counter transitions to STABLE_CYCLES, the decoded value, err and blank are written into slot i (the low dig_sel bit) and captured[i] is set.
  - Only one capture happens per dwell. A re-capture needs a change followed by a new stable run.
  - Capture latency is STABLE_CYCLES cycles from the first sample of the dwell.
- States:
  - COLLECT: captures update the slots. When all captured[] bits are set, copy the slots to the frame outputs, clear captured[], assert frame_valid on the next cycle, and go to PRESENT.
  - PRESENT: frame outputs are frozen; capture into the slots continues.
    - On frame_valid & frame_ready, deassert frame_valid next cycle. If captured[] is all set at that point, reload immediately and stay in PRESENT (back-to-back frames). Otherwise go to COLLECT.
    - If captured[] becomes all set while the current frame is not yet accepted, pulse overrun for 1 cycle, discard the new frame, and clear captured[].
- Simultaneous events: handshake acceptance and completion of a new frame on the same cycle -> the new frame is loaded and there is no overrun.
- Recapturing a digit before the frame completes overwrites its slot (last capture wins).
- Reset (rst_n low at an edge), including mid-frame:
  - frame_data=0, frame_err=0, frame_blank=0, frame_valid=0, overrun=0.
  - Counter, previous sample, slots and captured[] are cleared; state = COLLECT.

Test Plan:
- STABLE_CYCLES=4; scan digits 0..3 with patterns 79,24,30,19, 6 cycles each -> frame_valid rises 1 cycle after the 4th capture; frame_data=16'h4321, err=0, blank=0.
- Digit 2 glitches 24->25 on its 3rd dwell cycle, then holds 25 for 4 cycles -> slot 2 is captured from 25: err[2]=1, value 0; no capture from the 24 run.
- dig_sel=4'b1100 (two digits low) held for 10 cycles -> no capture, counter stays 0.
- Patterns 7F and 0E on digits 0 and 1 -> blank[0]=1, frame_data[7:0]=8'hF0.
- frame_ready held low while a second full scan completes -> overrun pulses 1 cycle and the first frame is unchanged; then ready=1 -> frame_valid drops next cycle.
- rst_n low for 1 cycle in the middle of digit 2's dwell -> all outputs 0 next cycle; a new full scan produces a correct frame.

Source files
------------

// File: rtl/seg_scan_reader_if.sv
// Bus bundle for seg_scan_reader: the scanned seven-segment input side and the
// frame valid/ready output side. master = the reader, slave = bus driver/consumer.
interface seg_scan_reader_if #(
  parameter int unsigned DIGITS = 4
);
  logic [7:0]          seg_in;
  logic [DIGITS-1:0]   dig_sel;
  logic [4*DIGITS-1:0] frame_data;
  logic [DIGITS-1:0]   frame_err;
  logic [DIGITS-1:0]   frame_blank;
  logic                frame_valid;
  logic                frame_ready;
  logic                overrun;

  modport master (
    input  seg_in,
    input  dig_sel,
    input  frame_ready,
    output frame_data,
    output frame_err,
    output frame_blank,
    output frame_valid,
    output overrun
  );

  modport slave (
    output seg_in,
    output dig_sel,
    output frame_ready,
    input  frame_data,
    input  frame_err,
    input  frame_blank,
    input  frame_valid,
    input  overrun
  );
endinterface

// File: rtl/seg_scan_reader.sv
// Reads back a multiplexed active-low seven-segment bus: debounces each digit
// dwell, reverse-decodes the glyph and presents one nibble per digit as a frame.
module seg_scan_reader #(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input logic               clk,
  input logic               rst_n,
  seg_scan_reader_if.master bus
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam int unsigned SW = 7 + DIGITS;
  localparam logic [CW-1:0] CntMax = CW'(STABLE_CYCLES);

  typedef enum logic [0:0] {StCollect, StPresent} state_e;

  // Returns {blank, err, value}.
  function automatic logic [5:0] glyph_decode(input logic [6:0] pat);
    logic [5:0] r;
    r = 6'b01_0000;
    case (pat)
      7'h40:   r = 6'h00;
      7'h79:   r = 6'h01;
      7'h24:   r = 6'h02;
      7'h30:   r = 6'h03;
      7'h19:   r = 6'h04;
      7'h12:   r = 6'h05;
      7'h02:   r = 6'h06;
      7'h78:   r = 6'h07;
      7'h00:   r = 6'h08;
      7'h10:   r = 6'h09;
      7'h08:   r = 6'h0A;
      7'h03:   r = 6'h0B;
      7'h46:   r = 6'h0C;
      7'h21:   r = 6'h0D;
      7'h06:   r = 6'h0E;
      7'h0E:   r = 6'h0F;
      7'h7F:   r = 6'b10_0000;
      default: r = 6'b01_0000;
    endcase
    return r;
  endfunction

  state_e              state_q, state_d;
  logic [SW-1:0]       sample, prev_q;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [DIGITS-1:0]   sel_oh;
  logic                sel_ok, same, capture;
  logic [5:0]          dec;
  logic [DIGITS-1:0]   cap_bits;
  logic [DIGITS-1:0]   captured_q, captured_d;
  logic                all_set, load, drop;
  logic [4*DIGITS-1:0] slot_val_q;
  logic [DIGITS-1:0]   slot_err_q, slot_blank_q;
  logic [4*DIGITS-1:0] frame_data_q;
  logic [DIGITS-1:0]   frame_err_q, frame_blank_q;
  logic                overrun_q;

  assign sel_oh = ~bus.dig_sel;
  assign sel_ok = $onehot(sel_oh);
  assign sample = {bus.seg_in[6:0], bus.dig_sel};
  assign same   = (sample == prev_q);
  assign dec    = glyph_decode(bus.seg_in[6:0]);

  always_comb begin
    cnt_d = '0;
    if (sel_ok) begin
      if (!same) begin
        cnt_d = CW'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end else begin
        cnt_d = cnt_q;
      end
    end
  end

  // A fresh sample that alone reaches the threshold also counts as a new arrival.
  assign capture  = sel_ok && (cnt_d == CntMax) && (!same || (cnt_q != CntMax));
  assign cap_bits = capture ? sel_oh : '0;
  assign all_set  = &captured_q;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    drop    = 1'b0;
    unique case (state_q)
      StCollect: begin
        if (all_set) begin
          load    = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (bus.frame_ready) begin
          if (all_set) begin
            load = 1'b1;
          end else begin
            state_d = StCollect;
          end
        end else if (all_set) begin
          drop = 1'b1;
        end
      end
      default: state_d = StCollect;
    endcase
  end

  // A capture landing on the load/drop cycle starts the next frame.
  assign captured_d = ((load || drop) ? '0 : captured_q) | cap_bits;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= StCollect;
      prev_q        <= '0;
      cnt_q         <= '0;
      captured_q    <= '0;
      slot_val_q    <= '0;
      slot_err_q    <= '0;
      slot_blank_q  <= '0;
      frame_data_q  <= '0;
      frame_err_q   <= '0;
      frame_blank_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      prev_q     <= sample;
      cnt_q      <= cnt_d;
      captured_q <= captured_d;
      overrun_q  <= drop;
      for (int i = 0; i < int'(DIGITS); i++) begin
        if (cap_bits[i]) begin
          slot_val_q[4*i +: 4] <= dec[3:0];
          slot_err_q[i]        <= dec[4];
          slot_blank_q[i]      <= dec[5];
        end
      end
      if (load) begin
        frame_data_q  <= slot_val_q;
        frame_err_q   <= slot_err_q;
        frame_blank_q <= slot_blank_q;
      end
    end
  end

  assign bus.frame_data  = frame_data_q;
  assign bus.frame_err   = frame_err_q;
  assign bus.frame_blank = frame_blank_q;
  assign bus.frame_valid = (state_q == StPresent);
  assign bus.overrun     = overrun_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Self-checking bench for seg_scan_reader: table-driven frames, directed corner
// sequences, and a randomized scan checked against a dwell-level reference model.
module tb_seg_scan_reader;
  localparam int unsigned DIGITS = 4;
  localparam int unsigned STABLE = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seg_scan_reader_if #(.DIGITS(DIGITS)) bus ();

  seg_scan_reader #(
    .DIGITS       (DIGITS),
    .STABLE_CYCLES(STABLE)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  err;
    logic [3:0]  blank;
  } frame_t;

  typedef struct {
    logic [27:0] pats;
    logic [15:0] data;
    logic [3:0]  err;
    logic [3:0]  blank;
  } vec_t;

  int unsigned n_cmp = 0;
  int unsigned n_fail = 0;
  int unsigned ovr_cnt = 0;
  int unsigned n_rand_frames = 0;
  bit          mon_en = 1'b0;
  frame_t      exp_q[$];
  logic [6:0]  glyph[16];

  function automatic logic [5:0] ref_decode(input logic [6:0] p);
    if (p == 7'h7F) return 6'b10_0000;
    for (int v = 0; v < 16; v++) begin
      if (glyph[v] == p) return {2'b00, 4'(v)};
    end
    return 6'b01_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, want, $time);
    end
  endtask

  task automatic step();
    frame_t e;
    @(posedge clk);
    #1;
    if (bus.overrun === 1'b1) ovr_cnt++;
    if (mon_en && bus.frame_valid === 1'b1 && bus.frame_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("rand_unexpected_frame", 32'(bus.frame_data), 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        n_rand_frames++;
        chk("rand_data", 32'(bus.frame_data), 32'(e.data));
        chk("rand_err", 32'(bus.frame_err), 32'(e.err));
        chk("rand_blank", 32'(bus.frame_blank), 32'(e.blank));
      end
    end
  endtask

  task automatic idle(input int n);
    bus.dig_sel = '1;
    bus.seg_in  = 8'hFF;
    repeat (n) step();
  endtask

  // dp (bit 7) is toggled randomly to show it has no effect.
  task automatic dwell(input int d, input logic [6:0] pat, input int n);
    for (int c = 0; c < n; c++) begin
      bus.dig_sel = ~(4'b0001 << d);
      bus.seg_in  = {1'($urandom_range(0, 1)), pat};
      step();
    end
  endtask

  task automatic scan(input logic [27:0] pats, input int n);
    for (int d = 0; d < 4; d++) dwell(d, pats[7*d +: 7], n);
  endtask

  task automatic accept();
    bus.frame_ready = 1'b1;
    step();
    chk("accept_valid_drop", 32'(bus.frame_valid), 32'd0);
    bus.frame_ready = 1'b0;
  endtask

  task automatic chk_frame(input string tag, input logic [15:0] d, input logic [3:0] e,
                           input logic [3:0] b);
    chk({tag, "_valid"}, 32'(bus.frame_valid), 32'd1);
    chk({tag, "_data"}, 32'(bus.frame_data), 32'(d));
    chk({tag, "_err"}, 32'(bus.frame_err), 32'(e));
    chk({tag, "_blank"}, 32'(bus.frame_blank), 32'(b));
  endtask

  vec_t vecs[5];

  initial begin
    int unsigned ovr0;
    int          last_d;
    int          gap, d, len, r;
    logic [6:0]  pat;
    logic [5:0]  dv;
    logic [3:0]  m_cap;
    frame_t      m_f;

    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    vecs[0] = '{{7'h19, 7'h30, 7'h24, 7'h79}, 16'h4321, 4'b0000, 4'b0000};
    vecs[1] = '{{7'h00, 7'h40, 7'h0E, 7'h7F}, 16'h80F0, 4'b0000, 4'b0001};
    vecs[2] = '{{7'h10, 7'h78, 7'h02, 7'h12}, 16'h9765, 4'b0000, 4'b0000};
    vecs[3] = '{{7'h21, 7'h46, 7'h03, 7'h08}, 16'hDCBA, 4'b0000, 4'b0000};
    vecs[4] = '{{7'h0E, 7'h7F, 7'h55, 7'h06}, 16'hF00E, 4'b0010, 4'b0100};

    rst_n           = 1'b0;
    bus.dig_sel     = '1;
    bus.seg_in      = 8'hFF;
    bus.frame_ready = 1'b0;
    step();
    step();
    chk("rst_valid", 32'(bus.frame_valid), 32'd0);
    chk("rst_data", 32'(bus.frame_data), 32'd0);
    chk("rst_err", 32'(bus.frame_err), 32'd0);
    chk("rst_blank", 32'(bus.frame_blank), 32'd0);
    chk("rst_overrun", 32'(bus.overrun), 32'd0);
    rst_n = 1'b1;
    idle(2);

    // Valid rises exactly one cycle after the last capture.
    dwell(0, 7'h79, 6);
    dwell(1, 7'h24, 6);
    dwell(2, 7'h30, 6);
    dwell(3, 7'h19, 4);
    chk("latency_before", 32'(bus.frame_valid), 32'd0);
    dwell(3, 7'h19, 1);
    chk_frame("latency", 16'h4321, 4'h0, 4'h0);
    accept();

    for (int i = 0; i < 5; i++) begin
      scan(vecs[i].pats, 6);
      chk_frame($sformatf("vec%0d", i), vecs[i].data, vecs[i].err, vecs[i].blank);
      accept();
    end

    // Glitch on digit 2: short run of 24 must not capture, 25 run does.
    dwell(0, 7'h79, 6);
    dwell(1, 7'h24, 6);
    dwell(3, 7'h19, 6);
    dwell(2, 7'h24, 2);
    chk("glitch_short_run", 32'(bus.frame_valid), 32'd0);
    dwell(2, 7'h25, 4);
    chk("glitch_pre_valid", 32'(bus.frame_valid), 32'd0);
    step();
    chk_frame("glitch", 16'h4021, 4'b0100, 4'b0000);
    accept();

    // Two digits low: must not capture into either slot.
    bus.dig_sel = 4'b1100;
    bus.seg_in  = 8'h79;
    repeat (10) step();
    dwell(2, 7'h30, 6);
    dwell(3, 7'h19, 6);
    dwell(1, 7'h24, 6);
    idle(5);
    chk("twolow_no_capture", 32'(bus.frame_valid), 32'd0);
    dwell(0, 7'h40, 6);
    chk_frame("twolow", 16'h4320, 4'h0, 4'h0);
    accept();

    // Overrun: second frame completes while first still unaccepted.
    scan(vecs[0].pats, 6);
    chk("ovr_first_valid", 32'(bus.frame_valid), 32'd1);
    ovr0 = ovr_cnt;
    scan(vecs[2].pats, 6);
    chk("ovr_pulse_cycles", ovr_cnt - ovr0, 32'd1);
    chk_frame("ovr_frozen", 16'h4321, 4'h0, 4'h0);
    idle(8);
    chk("ovr_still_frozen", 32'(bus.frame_data), 32'h4321);
    accept();

    // Acceptance coincides with completion of the next frame.
    scan(vecs[0].pats, 6);
    for (int k = 0; k < 3; k++) dwell(k, vecs[3].pats[7*k +: 7], 6);
    dwell(3, 7'h21, 4);
    ovr0 = ovr_cnt;
    bus.frame_ready = 1'b1;
    step();
    chk_frame("b2b", 16'hDCBA, 4'h0, 4'h0);
    chk("b2b_no_overrun", ovr_cnt - ovr0, 32'd0);
    step();
    chk("b2b_drop", 32'(bus.frame_valid), 32'd0);
    bus.frame_ready = 1'b0;

    // Reset in the middle of digit 2's dwell.
    idle(2);
    dwell(0, 7'h12, 6);
    dwell(1, 7'h02, 6);
    dwell(2, 7'h78, 2);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("midrst_valid", 32'(bus.frame_valid), 32'd0);
    chk("midrst_data", 32'(bus.frame_data), 32'd0);
    chk("midrst_err", 32'(bus.frame_err), 32'd0);
    chk("midrst_blank", 32'(bus.frame_blank), 32'd0);
    chk("midrst_overrun", 32'(bus.overrun), 32'd0);
    dwell(2, 7'h78, 6);
    dwell(3, 7'h10, 6);
    idle(4);
    chk("midrst_captured_cleared", 32'(bus.frame_valid), 32'd0);
    dwell(0, 7'h12, 6);
    dwell(1, 7'h02, 6);
    chk_frame("midrst", 16'h9765, 4'h0, 4'h0);
    accept();

    // Randomized dwells against a dwell-level model; consumer always ready.
    idle(2);
    ovr0            = ovr_cnt;
    m_cap           = '0;
    m_f             = '0;
    last_d          = -1;
    bus.frame_ready = 1'b1;
    mon_en          = 1'b1;
    for (int it = 0; it < 400; it++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      if (gap > 0) idle(gap);
      do d = int'($urandom_range(0, 3)); while (gap == 0 && d == last_d);
      r = int'($urandom_range(0, 9));
      if (r < 7) pat = glyph[$urandom_range(0, 15)];
      else if (r == 7) pat = 7'h7F;
      else pat = 7'($urandom_range(0, 127));
      len = int'($urandom_range(1, 7));
      if (len >= int'(STABLE)) begin
        dv                 = ref_decode(pat);
        m_f.data[4*d +: 4] = dv[3:0];
        m_f.err[d]         = dv[4];
        m_f.blank[d]       = dv[5];
        m_cap[d]           = 1'b1;
        if (&m_cap) begin
          exp_q.push_back(m_f);
          m_cap = '0;
        end
      end
      dwell(d, pat, len);
      last_d = d;
    end
    idle(6);
    mon_en = 1'b0;
    chk("rand_leftover_frames", 32'(exp_q.size()), 32'd0);
    chk("rand_no_overrun", ovr_cnt - ovr0, 32'd0);
    chk("rand_frames_seen_nonzero", 32'(n_rand_frames > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
